// File: rtl/ahbl_master_if.sv
// ahbl_master_if
//   Bundles the command/response stream and the AHB-Lite master-side bus
//   signals of one ahbl_master instance.
//   master modport: the initiator's view (cmd_* and HREADY/HRDATA/HRESP in,
//                   cmd_ready, rsp_* and H* address/control/data out).
//   slave modport:  the requester + interconnect view (mirror of master).
//
// Handshake: a command transfers on a rising HCLK edge where cmd_valid and
// cmd_ready are both 1; cmd_* fields must be stable while cmd_valid is high,
// and the requester keeps cmd_valid asserted until that edge. rsp_valid is a
// one-cycle pulse with no back-pressure; responses come back in command order.
interface ahbl_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  HREADY, HRDATA, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output HREADY, HRDATA, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahbl_master.sv
// ahbl_master
//   AHB-Lite single-transfer initiator. Each accepted command becomes one
//   NONSEQ transfer; the address phase of transfer N+1 overlaps the data phase
//   of transfer N, so with a zero-wait slave one command is issued per cycle.
//   One in-order response is returned per command.
// Ports
//   HCLK       clock
//   HRESET     synchronous, active-high reset
//   bus        ahbl_master_if.master: command stream, response pulse, AHB bus
//   dbg_state  current control state (0 = run, 1 = error hold)
// Parameters
//   HPROT_VAL  constant driven on HPROT
//   ID         instance tag for simulation messages; no hardware effect
module ahbl_master #(
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter logic [31:0] ID        = 32'h0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahbl_master_if.master        bus,
  output logic [0:0]           dbg_state
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  // ST_ERR_HOLD covers the second cycle of a two-cycle ERROR response.
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_ERR_HOLD = 1'b1
  } state_t;

  state_t      state;

  // A-stage: address/control live on HADDR/HSIZE/HWRITE, wdata held here.
  logic        a_pend;
  logic [31:0] a_wdata;
  // D-stage: transfer currently in its data phase.
  logic        d_valid;
  logic        d_write;

  logic        err_hold;
  logic        accept;
  logic        move;
  logic        complete;
  logic        err_set;
  logic        a_pend_nxt;
  logic        err_hold_nxt;

  assign err_hold      = (state == ST_ERR_HOLD);
  assign bus.cmd_ready = ~HRESET & ~err_hold & (~a_pend | bus.HREADY);
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // While in error hold the bus shows IDLE, so the pending command is not
  // sampled by the slave and must stay in the A-stage.
  assign move          = a_pend & ~err_hold & bus.HREADY;
  assign complete      = d_valid & bus.HREADY;
  assign err_set       = ~err_hold & d_valid & bus.HRESP & ~bus.HREADY;

  assign a_pend_nxt    = accept | (a_pend & ~move);
  assign err_hold_nxt  = err_set | (err_hold & ~bus.HREADY);

  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VAL;
  assign dbg_state     = state;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= ST_RUN;
      a_pend        <= 1'b0;
      a_wdata       <= '0;
      d_valid       <= 1'b0;
      d_write       <= 1'b0;
      bus.HTRANS    <= TR_IDLE;
      bus.HADDR     <= '0;
      bus.HSIZE     <= '0;
      bus.HWRITE    <= 1'b0;
      bus.HWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state  <= err_hold_nxt ? ST_ERR_HOLD : ST_RUN;
      a_pend <= a_pend_nxt;

      // HTRANS is registered from next-state so a command accepted during the
      // first error cycle still waits out the hold cycle as IDLE.
      bus.HTRANS <= (a_pend_nxt & ~err_hold_nxt) ? TR_NONSEQ : TR_IDLE;

      if (accept) begin
        bus.HADDR  <= bus.cmd_addr;
        bus.HSIZE  <= bus.cmd_size;
        bus.HWRITE <= bus.cmd_write;
        a_wdata    <= bus.cmd_wdata;
      end

      // HWRITE here is still the A-stage value being moved (non-blocking).
      if (move) begin
        d_valid    <= 1'b1;
        d_write    <= bus.HWRITE;
        bus.HWDATA <= a_wdata;
      end else if (complete) begin
        d_valid    <= 1'b0;
      end

      bus.rsp_valid <= complete;
      if (complete) begin
        bus.rsp_rdata <= d_write ? 32'h0 : bus.HRDATA;
        bus.rsp_err   <= bus.HRESP;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_master.sv
// tb_ahbl_master
//   Drives ahbl_master with directed and random commands while acting as an
//   AHB-Lite slave with planned wait states and ERROR responses. A
//   transaction-level model (pending-command queue, data-phase slot, expected
//   response queue) predicts bus activity, handshake readiness and responses.
`timescale 1ns/1ps
module tb_ahbl_master;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [0:0] dbg_state;

  ahbl_master_if bus ();

  ahbl_master #(.HPROT_VAL(4'b0011), .ID(32'h0)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- model state ----------------
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  waits;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  cmd_t        cmd_q[$];    // commands still to be offered
  cmd_t        pend_q[$];   // accepted, address phase not yet taken by slave
  plan_t       plan_q[$];   // directed slave behaviour, consumed per transfer
  logic [32:0] exp_q[$];    // {err, rdata} expected responses

  cmd_t        last_cmd;
  cmd_t        dq_cmd;
  plan_t       dq_plan;
  bit          dq_valid;
  bit          dq_err2;
  bit          rsp_due;
  bit          offering;
  logic [31:0] hw_exp;
  int          gap_pct;
  int          n_cmp;
  int          n_err;
  int          n_rsp;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic add_cmd(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    cmd_t c;
    c.write = w; c.addr = a; c.size = s; c.wdata = d;
    cmd_q.push_back(c);
  endtask

  task automatic add_plan(input int waits, input bit err, input logic [31:0] rd);
    plan_t p;
    p.waits = 4'(waits); p.err = err; p.rdata = rd;
    plan_q.push_back(p);
  endtask

  function automatic plan_t random_plan();
    plan_t p;
    p.waits = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
    p.err   = ($urandom_range(0, 99) < 12);
    p.rdata = $urandom();
    return p;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    plan_q.delete();
    exp_q.delete();
    last_cmd = '0;
    hw_exp   = '0;
    dq_valid = 1'b0;
    dq_err2  = 1'b0;
    rsp_due  = 1'b0;
    offering = 1'b0;
  endtask

  // One bus cycle: drive slave + requester at the falling edge, check the
  // registered outputs of this cycle, then advance the model to the next edge.
  task automatic tick(input bit rst);
    bit          s_ready;
    bit          s_resp;
    bit          err_idle;
    bit          last_cyc;
    bit          acc;
    cmd_t        c;
    logic [32:0] e;
    @(negedge HCLK);
    s_ready = 1'b1; s_resp = 1'b0; err_idle = 1'b0; last_cyc = 1'b0;
    if (dq_valid) begin
      if (dq_plan.waits != 4'd0) begin
        s_ready = 1'b0;
      end else if (dq_plan.err && !dq_err2) begin
        s_ready = 1'b0; s_resp = 1'b1;
      end else begin
        s_resp = dq_plan.err; err_idle = dq_plan.err; last_cyc = 1'b1;
      end
    end
    bus.HREADY = s_ready;
    bus.HRESP  = s_resp;
    bus.HRDATA = (last_cyc && !dq_cmd.write) ? dq_plan.rdata : $urandom();

    if (bus.rsp_valid === 1'b1) n_rsp++;
    check_eq("rsp_valid", bus.rsp_valid, rsp_due);
    if (rsp_due) begin
      e = exp_q.pop_front();
      if (bus.rsp_valid === 1'b1) begin
        check_eq("rsp_rdata", bus.rsp_rdata, e[31:0]);
        check_eq("rsp_err", bus.rsp_err, e[32]);
      end
    end
    check_eq("htrans", bus.HTRANS, (pend_q.size() > 0 && !err_idle) ? 2'b10 : 2'b00);
    check_eq("haddr", bus.HADDR, last_cmd.addr);
    check_eq("hwrite", bus.HWRITE, last_cmd.write);
    check_eq("hsize", bus.HSIZE, last_cmd.size);
    check_eq("hwdata", bus.HWDATA, hw_exp);
    check_eq("hprot", bus.HPROT, 4'b0011);
    check_eq("hburst", bus.HBURST, 3'b000);
    check_eq("dbg_state", dbg_state, err_idle);

    HRESET = rst;
    if (rst) offering = 1'b0;
    else if (!offering && cmd_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) offering = 1'b1;
    if (offering) begin
      c = cmd_q[0];
    end else begin
      c.write = 1'($urandom_range(0, 1));
      c.addr  = $urandom();
      c.size  = 3'($urandom_range(0, 7));
      c.wdata = $urandom();
    end
    bus.cmd_valid = offering;
    bus.cmd_write = c.write;
    bus.cmd_addr  = c.addr;
    bus.cmd_size  = c.size;
    bus.cmd_wdata = c.wdata;

    #1;
    check_eq("cmd_ready", bus.cmd_ready,
             rst ? 1'b0 : (!err_idle && (pend_q.size() == 0 || s_ready)));
    acc = offering && (bus.cmd_ready === 1'b1);

    if (rst) begin
      model_reset();
    end else begin
      rsp_due = 1'b0;
      if (dq_valid) begin
        if (dq_plan.waits != 4'd0) begin
          dq_plan.waits = dq_plan.waits - 4'd1;
        end else if (dq_plan.err && !dq_err2) begin
          dq_err2 = 1'b1;
        end else begin
          exp_q.push_back({dq_plan.err, dq_cmd.write ? 32'h0 : dq_plan.rdata});
          rsp_due  = 1'b1;
          dq_valid = 1'b0;
        end
      end
      if (pend_q.size() > 0 && !err_idle && s_ready) begin
        dq_cmd   = pend_q.pop_front();
        dq_valid = 1'b1;
        dq_err2  = 1'b0;
        hw_exp   = dq_cmd.wdata;
        dq_plan  = (plan_q.size() > 0) ? plan_q.pop_front() : random_plan();
      end
      if (acc) begin
        c = cmd_q.pop_front();
        pend_q.push_back(c);
        last_cmd = c;
        offering = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || offering || pend_q.size() > 0 || dq_valid || rsp_due) && n < budget) begin
      tick(1'b0);
      n++;
    end
    check_eq(tag, (n < budget), 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    n_cmp = 0; n_err = 0; n_rsp = 0; gap_pct = 0;
    model_reset();
    HRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = '0;
    bus.cmd_wdata = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("rst_htrans", bus.HTRANS, 2'b00);
    check_eq("rst_haddr", bus.HADDR, 32'h0);
    check_eq("rst_hsize", bus.HSIZE, 3'b000);
    check_eq("rst_hwrite", bus.HWRITE, 1'b0);
    check_eq("rst_hwdata", bus.HWDATA, 32'h0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b0);

    // Single zero-wait read.
    add_cmd(1'b0, 32'h100, 3'b010, 32'h0);
    add_plan(0, 1'b0, 32'hDEADBEEF);
    drain("t1_drain", 50);

    // Four back-to-back writes.
    r0 = n_rsp;
    for (int i = 0; i < 4; i++) begin
      add_cmd(1'b1, 32'(i * 4), 3'b010, 32'(i + 1));
      add_plan(0, 1'b0, 32'h0);
    end
    drain("t2_drain", 50);
    check_eq("t2_rsp_count", n_rsp - r0, 4);

    // Write with three wait states followed by a read.
    add_cmd(1'b1, 32'h20, 3'b010, 32'h1234_5678);
    add_plan(3, 1'b0, 32'h0);
    add_cmd(1'b0, 32'h24, 3'b010, 32'h0);
    add_plan(0, 1'b0, 32'hCAFE_0024);
    drain("t3_drain", 50);

    // ERROR on a read with another read queued behind it.
    r0 = n_rsp;
    add_cmd(1'b0, 32'h40, 3'b010, 32'h0);
    add_plan(0, 1'b1, 32'h0BAD_0040);
    add_cmd(1'b0, 32'h44, 3'b010, 32'h0);
    add_plan(0, 1'b0, 32'h600D_0044);
    drain("t4_drain", 50);
    check_eq("t4_rsp_count", n_rsp - r0, 2);

    // Reset during a waited data phase: the read is abandoned.
    add_cmd(1'b0, 32'h80, 3'b010, 32'h0);
    add_plan(6, 1'b0, 32'h1111_2222);
    repeat (4) tick(1'b0);
    r0 = n_rsp;
    tick(1'b1);
    drain("t5_drain", 20);
    repeat (8) tick(1'b0);
    check_eq("t5_no_rsp", n_rsp - r0, 0);

    // Byte write, passed through unmodified.
    add_cmd(1'b1, 32'h3, 3'b000, 32'hAA00_0000);
    add_plan(0, 1'b0, 32'h0);
    drain("t6_drain", 50);

    // Random traffic with random gaps, wait states and errors.
    gap_pct = 30;
    r0 = n_rsp;
    for (int i = 0; i < 300; i++) begin
      add_cmd(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
              3'($urandom_range(0, 2)), $urandom());
    end
    drain("rand_drain", 6000);
    check_eq("rand_rsp_count", n_rsp - r0, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
